// File: rtl/alu_control_seq.sv
// alu_control_seq: decodes {alu_op, funct} into an ALU operation code and
// sequences multi-cycle MULT/MULTU/DIV/DIVU with a stall-generating FSM.
module alu_control_seq #(
    parameter int ALU_OP_WIDTH = 3,
    parameter int MUL_CYCLES   = 4,
    parameter int DIV_CYCLES   = 32,
    parameter bit REG_OUT      = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_i,
    input  logic                    flush_i,
    input  logic [ALU_OP_WIDTH-1:0] alu_op_i,
    input  logic [5:0]              alu_function_i,
    output logic [3:0]              alu_operation_o,
    output logic                    md_start_o,
    output logic [1:0]              md_op_o,
    output logic                    stall_o,
    output logic                    hilo_we_o,
    output logic                    busy_o
);
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    md_op_q, md_op_d;
    logic [3:0]    code, alu_q, alu_d;
    logic [2:0]    op;
    logic          op_ok, md_req, start;

    assign op     = alu_op_i[2:0];
    assign op_ok  = (alu_op_i >> 3) == '0;
    assign md_req = valid_i & op_ok & (op == 3'b111) & (alu_function_i[5:2] == 4'b0110);
    // Start is gated by reset so no pulse escapes while reset is asserted.
    assign start  = reset & (state_q == IDLE) & md_req & ~flush_i;

    always_comb begin
        code = 4'b1001;
        if (op_ok) begin
            case (op)
                3'b111: begin
                    case (alu_function_i)
                        6'b100000: code = 4'b0011;
                        6'b100010: code = 4'b0100;
                        6'b100100: code = 4'b0110;
                        6'b100101: code = 4'b0010;
                        6'b100111: code = 4'b0111;
                        6'b101010: code = 4'b1011;
                        6'b000000: code = 4'b1000;
                        6'b000010: code = 4'b1010;
                        6'b010000: code = 4'b1100;
                        6'b010010: code = 4'b1101;
                        6'b011000, 6'b011001, 6'b011010, 6'b011011: code = 4'b1110;
                        default:   code = 4'b1001;
                    endcase
                end
                3'b100, 3'b011: code = 4'b0011;
                3'b101:         code = 4'b0010;
                3'b001:         code = 4'b0110;
                3'b110:         code = 4'b0101;
                3'b010:         code = 4'b0100;
                default:        code = 4'b1001;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        md_op_d = md_op_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    md_op_d = alu_function_i[1:0];
                    cnt_d   = alu_function_i[1] ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
                end
            end
            RUN: begin
                if (flush_i) state_d = IDLE;
                else if (cnt_q == '0) state_d = DONE;
                else cnt_d = cnt_q - CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // The stalled instruction is the mul/div itself, so the code is captured
    // in the start cycle and frozen only while the unit runs.
    assign alu_d = (state_q == RUN) ? alu_q : code;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            md_op_q <= 2'b00;
            alu_q   <= 4'b1001;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            md_op_q <= md_op_d;
            alu_q   <= alu_d;
        end
    end

    assign alu_operation_o = REG_OUT ? alu_q : code;
    assign md_start_o      = start;
    assign md_op_o         = start ? alu_function_i[1:0] : md_op_q;
    assign stall_o         = start | (state_q == RUN);
    assign hilo_we_o       = state_q == DONE;
    assign busy_o          = state_q != IDLE;
endmodule
